// File: rtl/rr_arbiter42.sv
// rr_arbiter42: four-requester round-robin arbiter with a grant hold limit.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   req[3:0]  request lines, bit i belongs to requester i
//   gnt[3:0]  one-hot grant, zero when no owner
//   gnt_id    encoded index of the owner, zero when no owner
//   gnt_valid high while a grant is held
//   timeout   one-cycle pulse in the idle cycle after a forced release
//
// A grant is held while the owner keeps requesting, for at most MAX_HOLD
// cycles. Every release passes through exactly one IDLE cycle, and the
// priority pointer moves to the requester after the one just released.
module rr_arbiter42 #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_t           state, state_nxt;
    logic [1:0]       owner, owner_nxt;
    logic [1:0]       ptr, ptr_nxt;
    logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;
    logic             timeout_nxt;

    logic       found;
    logic [1:0] winner;
    logic [1:0] idx;

    // First set request at or after ptr, wrapping modulo 4.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            idx = ptr + 2'(i);
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            owner    <= '0;
            ptr      <= '0;
            hold_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            ptr      <= ptr_nxt;
            hold_cnt <= hold_cnt_nxt;
            timeout  <= timeout_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        owner_nxt    = owner;
        ptr_nxt      = ptr;
        hold_cnt_nxt = hold_cnt;
        timeout_nxt  = 1'b0;
        unique case (state)
            IDLE: begin
                if (found) begin
                    owner_nxt    = winner;
                    hold_cnt_nxt = '0;
                    state_nxt    = BUSY;
                end
            end
            BUSY: begin
                if (!req[owner]) begin
                    state_nxt = IDLE;
                    ptr_nxt   = owner + 2'd1;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_nxt   = IDLE;
                    ptr_nxt     = owner + 2'd1;
                    timeout_nxt = 1'b1;
                end else begin
                    hold_cnt_nxt = hold_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decode only registered state, so they stay mutually
    // consistent and clear together the moment rst is asserted.
    always_comb begin
        gnt       = '0;
        gnt_id    = '0;
        gnt_valid = 1'b0;
        if (state == BUSY) begin
            gnt[owner] = 1'b1;
            gnt_id     = owner;
            gnt_valid  = 1'b1;
        end
    end

endmodule

// File: tb/tb_rr_arbiter42.sv
module tb_rr_arbiter42;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req8 = '0;
    logic [3:0] req1 = '0;

    logic [3:0] gnt8, gnt1;
    logic [1:0] id8, id1;
    logic       val8, val1;
    logic       to8, to1;

    int n_pass  = 0;
    int n_total = 0;
    bit run_chk = 1'b0;

    always #5 clk = ~clk;

    rr_arbiter42 #(.MAX_HOLD(8), .CNT_W(4)) u_dut8 (
        .clk(clk), .rst(rst), .req(req8),
        .gnt(gnt8), .gnt_id(id8), .gnt_valid(val8), .timeout(to8)
    );

    rr_arbiter42 #(.MAX_HOLD(1), .CNT_W(4)) u_dut1 (
        .clk(clk), .rst(rst), .req(req1),
        .gnt(gnt1), .gnt_id(id1), .gnt_valid(val1), .timeout(to1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // Behavioural model: busy flag, owner, rotating priority pointer and the
    // number of cycles the current grant has been visible so far.
    int m_busy[2]  = '{0, 0};
    int m_owner[2] = '{0, 0};
    int m_ptr[2]   = '{0, 0};
    int m_cnt[2]   = '{0, 0};
    int m_to[2]    = '{0, 0};
    int lim[2]     = '{8, 1};
    logic [3:0] m_r;
    int m_w;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                m_busy[k] = 0; m_owner[k] = 0; m_ptr[k] = 0; m_cnt[k] = 0; m_to[k] = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                m_r = (k == 0) ? req8 : req1;
                m_to[k] = 0;
                if (m_busy[k] == 0) begin
                    m_w = -1;
                    for (int j = 0; j < 4; j++)
                        if (m_w < 0 && m_r[(m_ptr[k] + j) % 4]) m_w = (m_ptr[k] + j) % 4;
                    if (m_w >= 0) begin
                        m_busy[k] = 1; m_owner[k] = m_w; m_cnt[k] = 1;
                    end
                end else if (!m_r[m_owner[k]]) begin
                    m_busy[k] = 0; m_ptr[k] = (m_owner[k] + 1) % 4;
                end else if (m_cnt[k] == lim[k]) begin
                    m_busy[k] = 0; m_ptr[k] = (m_owner[k] + 1) % 4; m_to[k] = 1;
                end else begin
                    m_cnt[k] = m_cnt[k] + 1;
                end
            end
        end
    end

    // Continuous comparison against the model on every falling edge.
    logic [3:0] eg;
    always @(negedge clk) begin
        if (run_chk) begin
            eg = m_busy[0] ? (4'b0001 << m_owner[0]) : 4'b0000;
            chk("m8_gnt", gnt8, eg);
            chk("m8_id", id8, m_busy[0] ? m_owner[0] : 0);
            chk("m8_valid", val8, m_busy[0]);
            chk("m8_timeout", to8, m_to[0]);
            eg = m_busy[1] ? (4'b0001 << m_owner[1]) : 4'b0000;
            chk("m1_gnt", gnt1, eg);
            chk("m1_id", id1, m_busy[1] ? m_owner[1] : 0);
            chk("m1_valid", val1, m_busy[1]);
            chk("m1_timeout", to1, m_to[1]);
        end
    end

    task automatic step(input logic [3:0] r8, input logic [3:0] r1);
        req8 = r8;
        req1 = r1;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_gnt8", gnt8, 4'b0000);
        chk("rst_id8", id8, 2'd0);
        chk("rst_valid8", val8, 1'b0);
        chk("rst_to8", to8, 1'b0);
        chk("rst_gnt1", gnt1, 4'b0000);
        @(posedge clk);
        #2;
        rst  = 1'b0;
        req8 = '0;
        req1 = '0;
    endtask

    int         ord[4]  = '{3, 0, 1, 2};
    logic [3:0] exp1[8] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b0000};
    logic       eto1[8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [3:0] r8, r1;

    initial begin
        @(posedge clk);
        #2;
        run_chk = 1'b1;
        do_reset();

        // Single requester 2 for three sampled cycles.
        step(4'b0100, 4'b0000);
        chk("t1_gnt", gnt8, 4'b0100);
        chk("t1_id", id8, 2'd2);
        step(4'b0100, 4'b0000);
        step(4'b0100, 4'b0000);
        chk("t1_gnt_last", gnt8, 4'b0100);
        step(4'b0000, 4'b0000);
        chk("t1_released", gnt8, 4'b0000);
        chk("t1_no_timeout", to8, 1'b0);

        // All requesting: rotation 3,0,1,2 with forced releases.
        foreach (ord[i]) begin
            for (int c = 0; c < 8; c++) begin
                step(4'b1111, 4'b0000);
                chk("t2_gnt", gnt8, 4'b0001 << ord[i]);
            end
            step(4'b1111, 4'b0000);
            chk("t2_gap", gnt8, 4'b0000);
            chk("t2_gap_timeout", to8, 1'b1);
        end

        // Lone requester 1 is re-granted after its forced release.
        for (int c = 0; c < 8; c++) begin
            step(4'b0010, 4'b0000);
            chk("t3_gnt", gnt8, 4'b0010);
        end
        step(4'b0010, 4'b0000);
        chk("t3_gap_timeout", to8, 1'b1);
        step(4'b0010, 4'b0000);
        chk("t3_regrant", gnt8, 4'b0010);
        step(4'b0000, 4'b0000);

        // Simultaneous 0 and 3 from reset.
        do_reset();
        step(4'b1001, 4'b0000);
        chk("t4_first", gnt8, 4'b0001);
        step(4'b1000, 4'b0000);
        chk("t4_gap", gnt8, 4'b0000);
        step(4'b1000, 4'b0000);
        chk("t4_second", gnt8, 4'b1000);
        chk("t4_second_id", id8, 2'd3);

        // Asynchronous reset mid-grant, then restart from ptr 0.
        do_reset();
        step(4'b1111, 4'b0000);
        chk("t6_after_rst", gnt8, 4'b0001);
        step(4'b0000, 4'b0000);

        // MAX_HOLD=1 instance alternating between 0 and 1.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            step(4'b0000, 4'b0011);
            chk("t5_gnt", gnt1, exp1[k]);
            chk("t5_timeout", to1, eto1[k]);
        end

        // Randomized traffic with sticky requests and rare resets.
        r8 = '0;
        r1 = '0;
        for (int n = 0; n < 4000; n++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 5) == 0) r8[b] = ~r8[b];
                if ($urandom_range(0, 5) == 0) r1[b] = ~r1[b];
            end
            rst = ($urandom_range(0, 399) == 0);
            step(r8, r1);
        end
        rst = 1'b0;
        step(4'b0000, 4'b0000);

        run_chk = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rr_arbiter42.md
# rr_arbiter42

Four-requester round-robin arbiter that shares one downstream resource among four clients. It produces a registered one-hot grant and a 2-bit encoded grant index for the shared datapath's select lines. Grants are held while the owner keeps its request asserted, up to a programmable cycle limit. On release, priority rotates so that no requester starves.

## Interface
Parameters:
- MAX_HOLD, default 8: maximum consecutive grant cycles per owner. Legal range 1..2^CNT_W.
- CNT_W, default 4: width of the hold counter.

Ports:
- clk  input  1  rising-edge clock, the only clock.
- rst  input  1  asynchronous, active-high reset.
- req  input  4  request from each requester; bit i belongs to requester i.
- gnt  output  4  registered one-hot grant; all zero when no owner.
- gnt_id  output  2  registered index of the current owner; 0 when no owner.
- gnt_valid  output  1  registered; high when gnt is nonzero.
- timeout  output  1  one-cycle pulse marking a forced release.

## Operation
- State register: IDLE or BUSY. Also holds owner[1:0], ptr[1:0] (highest-priority index) and hold_cnt[CNT_W-1:0].
- Reset (async, immediate): state=IDLE, owner=0, ptr=0, hold_cnt=0. Outputs gnt=0000, gnt_id=0, gnt_valid=0, timeout=0.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise pick the first set bit searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - Load owner with the winner, clear hold_cnt and go to BUSY.
- BUSY:
  - gnt = 1<<owner, gnt_id = owner, gnt_valid = 1.
  - Each cycle, req[owner] is checked first:
    - req[owner]=0 (voluntary release): go to IDLE, ptr <= owner+1 mod 4.
    - req[owner]=1 and hold_cnt==MAX_HOLD-1 (forced release): go to IDLE, ptr <= owner+1 mod 4, and pulse timeout in the following cycle.
    - Otherwise hold_cnt <= hold_cnt+1 and stay in BUSY.
  - Requests from non-owners are ignored while in BUSY.
- Each release inserts exactly one IDLE cycle with gnt=0 before the next grant. This is the dead cycle that lets the shared resource drain.
- ptr wraps 3→0. ptr changes only on release.
- Counter arithmetic: hold_cnt never exceeds MAX_HOLD-1 and never wraps.
- With MAX_HOLD=1, every grant lasts exactly one cycle.
- gnt, gnt_id and gnt_valid are always mutually consistent. gnt never has more than one bit set.

## Timing
- Grant latency: req sampled high at edge n while IDLE → gnt visible after edge n (cycle n+1).
- Release latency: req[owner] sampled low at edge m → gnt=0 after edge m.
  - The owner therefore sees gnt high in the cycle it dropped req.
- Next grant: new owner sampled at edge m+1 → gnt after edge m+1.
- Maximum grant length: MAX_HOLD cycles. timeout is high during the IDLE cycle immediately after a forced release and low otherwise.
- Simultaneous requests: resolved purely by ptr order within the same edge.
- A requester that drops and re-raises req during its own BUSY cycles:
  - The drop releases the grant.
  - The re-request competes normally, with lowest priority because ptr has moved past it.
- Reset asserted mid-grant: gnt drops to 0 without waiting for a clock edge. The first grant after reset deassertion uses ptr=0.

## Test plan
- Reset, then req=0100 for 3 cycles, then 0000:
  - gnt=0100 and gnt_id=2 from the cycle after the first request, lasting 3 cycles.
  - Then gnt=0000, and ptr=3 (verified by the next test step).
- After the previous step, req=1111 held, MAX_HOLD=8:
  - Grants go to 3, 0, 1, 2 in that order, each exactly 8 cycles.
  - One gnt=0000 cycle between grants, with timeout=1 in each gap.
- Only requester 1 holding req continuously:
  - gnt=0010 for 8 cycles, then 1 idle cycle with timeout=1, then gnt=0010 again. No starvation check is needed; the re-grant is required.
- From reset, req=1001 in the same cycle:
  - Winner is 0 (ptr=0).
  - After requester 0 releases, requester 3 is granted after exactly one idle cycle.
- MAX_HOLD=1 with req=0011 held:
  - Alternating grants 0, 1, 0, 1, each 1 cycle, separated by single idle cycles. timeout pulses after every grant.
- rst pulsed while gnt=1000:
  - gnt, gnt_id, gnt_valid and timeout go to 0 asynchronously.
  - After release with req=1111, the first grant goes to requester 0.
